// File: rtl/ofdm_remove_cp.sv
// ofdm_remove_cp: strips the cyclic prefix from framed OFDM symbols. Each symbol body goes into
// a two-bank ping-pong buffer and is streamed out under downstream flow control.
// Optional build macro: OFDM_RM_CP_OVF_EN adds a sticky o_overflow output.
module ofdm_remove_cp #(
  parameter int unsigned DATA_SIZE    = 16,
  parameter int unsigned SYMBOLS_SIZE = 256,
  parameter int unsigned CP_LENGHT    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_data_en,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  output logic                 o_wayt_recive_data,
  input  logic                 i_wayt_read_data,
  output logic                 output_en,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 out_first
`ifdef OFDM_RM_CP_OVF_EN
  ,
  output logic                 o_overflow
`endif
);

  localparam int unsigned FRAME = SYMBOLS_SIZE + CP_LENGHT;
  localparam int unsigned CW    = $clog2(FRAME);
  localparam int unsigned OW    = $clog2(SYMBOLS_SIZE);
  localparam int unsigned SW    = 2 * DATA_SIZE;

  logic [CW-1:0] cnt_in;
  logic [OW-1:0] cnt_out;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bank;
  logic          rd_bank;
  logic          accept;
  logic          in_prefix;
  logic          in_last;
  logic          rd_go;
  logic          rd_last;
  logic [OW-1:0] wr_idx;
  logic [SW-1:0] mem [2][SYMBOLS_SIZE];

  // Ready whenever the bank being written has been released by the reader
  assign o_wayt_recive_data = !full[wr_bank];
  assign accept  = in_data_en & o_wayt_recive_data;
  assign in_last = (cnt_in == CW'(FRAME - 1));
  assign wr_idx  = OW'(cnt_in - CW'(CP_LENGHT));
  assign rd_go   = full[rd_bank] & i_wayt_read_data;
  assign rd_last = (cnt_out == OW'(SYMBOLS_SIZE - 1));

  // Prefix detection; with no prefix every accepted sample belongs to the body
  generate
    if (CP_LENGHT > 0) begin : g_cp
      assign in_prefix = (cnt_in < CW'(CP_LENGHT));
    end else begin : g_no_cp
      assign in_prefix = 1'b0;
    end
  endgenerate

  // Input position within the framed symbol and active write bank
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_in  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        cnt_in  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        cnt_in <= cnt_in + CW'(1);
      end
    end
  end

  // Body sample storage; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && !in_prefix) begin
      mem[wr_bank][wr_idx] <= {in_data_i, in_data_q};
    end
  end

  // Bank-full flags: reader clears its bank, writer sets its bank; set wins on the same bank
  always_comb begin
    full_nxt = full;
    if (rd_go && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (accept && in_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Bank-full flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

  // Read side: one body sample per cycle while a full bank is available and downstream accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_out    <= '0;
      rd_bank    <= 1'b0;
      output_en  <= 1'b0;
      out_first  <= 1'b0;
      out_data_i <= '0;
      out_data_q <= '0;
    end else if (rd_go) begin
      {out_data_i, out_data_q} <= mem[rd_bank][cnt_out];
      output_en <= 1'b1;
      out_first <= (cnt_out == '0);
      if (rd_last) begin
        cnt_out <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        cnt_out <= cnt_out + OW'(1);
      end
    end else begin
      output_en <= 1'b0;
      out_first <= 1'b0;
    end
  end

`ifdef OFDM_RM_CP_OVF_EN
  // Sticky flag for any sample offered while the write bank was still occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (in_data_en && !o_wayt_recive_data) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_remove_cp.sv
// tb_ofdm_remove_cp: randomized self-checking bench for ofdm_remove_cp with a queue-based
// reference model; a second instance covers the prefix-free build.
`timescale 1ns/1ps
module tb_ofdm_remove_cp;

  localparam int unsigned DS = 16;
  localparam int unsigned S  = 8;
  localparam int unsigned CP = 2;

  typedef struct packed {
    logic          rdy;
    logic          en;
    logic          first;
    logic [DS-1:0] i;
    logic [DS-1:0] q;
    logic          ovf;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_data_en;
  logic [DS-1:0] in_data_i, in_data_q;
  logic o_wayt_recive_data;
  logic i_wayt_read_data;
  logic output_en;
  logic [DS-1:0] out_data_i, out_data_q;
  logic out_first;
  logic dut_ovf;

  logic en2;
  logic [DS-1:0] i2, q2;
  logic rdy2, rd2, oen2, of2;
  logic [DS-1:0] oi2, oq2;

`ifdef OFDM_RM_CP_OVF_EN
  logic ovf, ovf2;
  assign dut_ovf = ovf;
`else
  assign dut_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  ofdm_remove_cp #(.DATA_SIZE(DS), .SYMBOLS_SIZE(S), .CP_LENGHT(CP)) dut (
    .clk(clk), .reset(reset), .in_data_en(in_data_en), .in_data_i(in_data_i),
    .in_data_q(in_data_q), .o_wayt_recive_data(o_wayt_recive_data),
    .i_wayt_read_data(i_wayt_read_data), .output_en(output_en), .out_data_i(out_data_i),
    .out_data_q(out_data_q), .out_first(out_first)
`ifdef OFDM_RM_CP_OVF_EN
    , .o_overflow(ovf)
`endif
  );

  ofdm_remove_cp #(.DATA_SIZE(DS), .SYMBOLS_SIZE(S), .CP_LENGHT(0)) dut_nocp (
    .clk(clk), .reset(reset), .in_data_en(en2), .in_data_i(i2), .in_data_q(q2),
    .o_wayt_recive_data(rdy2), .i_wayt_read_data(rd2), .output_en(oen2),
    .out_data_i(oi2), .out_data_q(oq2), .out_first(of2)
`ifdef OFDM_RM_CP_OVF_EN
    , .o_overflow(ovf2)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: completed bodies kept in arrival order, read head tracked by index
  logic [2*DS-1:0] part[$];
  logic [2*DS-1:0] stored[$];
  int   pos = 0;
  int   rd_idx = 0;
  bit   m_rdy;
  logic m_en = 1'b0, m_first = 1'b0, m_ovf = 1'b0;
  logic [DS-1:0] m_i = '0, m_q = '0;

  always @(posedge clk) begin
    if (reset) begin
      part.delete(); stored.delete();
      pos = 0; rd_idx = 0;
      m_en = 1'b0; m_first = 1'b0; m_ovf = 1'b0; m_i = '0; m_q = '0;
    end else begin
      m_rdy = (stored.size() / S) < 2;
      if ((stored.size() / S) > 0 && i_wayt_read_data) begin
        {m_i, m_q} = stored[rd_idx];
        m_en = 1'b1;
        m_first = (rd_idx == 0);
        rd_idx++;
        if (rd_idx == S) begin
          repeat (S) void'(stored.pop_front());
          rd_idx = 0;
        end
      end else begin
        m_en = 1'b0;
        m_first = 1'b0;
      end
      if (in_data_en && m_rdy) begin
        if (pos >= CP) part.push_back({in_data_i, in_data_q});
        pos++;
        if (pos == S + CP) begin
          foreach (part[k]) stored.push_back(part[k]);
          part.delete();
          pos = 0;
        end
      end else if (in_data_en) begin
        m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle recording of DUT outputs next to model expectations
  rec_t obs_q[$];
  rec_t exp_q[$];
  logic [2*DS:0] out2_q[$];
  bit rec_on = 1'b0;

  always @(negedge clk) begin
    if (rec_on) begin
      obs_q.push_back({o_wayt_recive_data, output_en, out_first, out_data_i, out_data_q, dut_ovf});
`ifdef OFDM_RM_CP_OVF_EN
      exp_q.push_back({1'((stored.size() / S) < 2), m_en, m_first, m_i, m_q, m_ovf});
`else
      exp_q.push_back({1'((stored.size() / S) < 2), m_en, m_first, m_i, m_q, 1'b0});
`endif
    end
    if (oen2) out2_q.push_back({of2, oi2, oq2});
  end

  task automatic tick(input logic en, input logic [DS-1:0] i, input logic rd);
    in_data_en = en;
    in_data_i = i;
    in_data_q = DS'($urandom);
    i_wayt_read_data = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic open_window();
    obs_q.delete();
    exp_q.delete();
    rec_on = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (output_en !== 1'b0) begin fails++; $display("FAIL reset_en got %b exp 0", output_en); end
    tests++; if (out_first !== 1'b0) begin fails++; $display("FAIL reset_first got %b exp 0", out_first); end
    tests++; if (out_data_i !== '0 || out_data_q !== '0) begin
      fails++; $display("FAIL reset_data got %h/%h exp 0/0", out_data_i, out_data_q); end
    tests++; if (o_wayt_recive_data !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b exp 1", o_wayt_recive_data); end
    tests++; if (dut_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", dut_ovf); end
  endtask

  task automatic test_stream();
    int n;
    do_reset();
    open_window();
    for (int k = 0; k < 10; k++) tick(1'b1, DS'(k), 1'b1);
    repeat (12) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL stream cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
    n = 0;
    foreach (obs_q[k]) if (obs_q[k].en) begin
      tests++;
      if (obs_q[k].i !== DS'(n + 2) || obs_q[k].first !== (n == 0)) begin
        fails++; $display("FAIL stream_val #%0d got i=%0d first=%b exp i=%0d first=%b",
                          n, obs_q[k].i, obs_q[k].first, n + 2, n == 0);
      end
      n++;
    end
    tests++; if (n != 8) begin fails++; $display("FAIL stream_count got %0d exp 8", n); end
  endtask

  task automatic test_back_to_back();
    int n, stalls;
    do_reset();
    open_window();
    for (int k = 0; k < 30; k++) tick(1'b1, DS'(k), 1'b1);
    repeat (14) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL b2b cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
    n = 0; stalls = 0;
    foreach (obs_q[k]) begin
      if (!obs_q[k].rdy) stalls++;
      if (obs_q[k].en) begin
        tests++;
        if (obs_q[k].i !== DS'((n / 8) * 10 + 2 + n % 8) || obs_q[k].first !== (n % 8 == 0)) begin
          fails++; $display("FAIL b2b_val #%0d got i=%0d first=%b", n, obs_q[k].i, obs_q[k].first);
        end
        n++;
      end
    end
    tests++; if (n != 24) begin fails++; $display("FAIL b2b_count got %0d exp 24", n); end
    tests++; if (stalls != 0) begin fails++; $display("FAIL b2b_stall got %0d exp 0", stalls); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    open_window();
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, DS'(k), 1'b0);
      if (k == 19) begin
        tests++;
        if (o_wayt_recive_data !== 1'b0) begin
          fails++; $display("FAIL ovf_ready got %b exp 0", o_wayt_recive_data); end
      end
    end
`ifdef OFDM_RM_CP_OVF_EN
    tests++; if (dut_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", dut_ovf); end
`endif
    repeat (20) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL ovf cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
    n = 0;
    foreach (obs_q[k]) if (obs_q[k].en) begin
      tests++;
      if (obs_q[k].i !== DS'((n / 8) * 10 + 2 + n % 8)) begin
        fails++; $display("FAIL ovf_val #%0d got i=%0d", n, obs_q[k].i); end
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL ovf_count got %0d exp 16", n); end
  endtask

  task automatic test_toggle();
    int n;
    do_reset();
    open_window();
    for (int k = 0; k < 10; k++) tick(1'b1, DS'(k + 40), 1'b0);
    for (int k = 0; k < 20; k++) tick(1'b0, '0, 1'((k % 2) == 0));
    repeat (6) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL toggle cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
    n = 0;
    foreach (obs_q[k]) if (obs_q[k].en) begin
      tests++;
      if (obs_q[k].i !== DS'(42 + n)) begin
        fails++; $display("FAIL toggle_val #%0d got i=%0d exp %0d", n, obs_q[k].i, 42 + n); end
      n++;
    end
    tests++; if (n != 8) begin fails++; $display("FAIL toggle_count got %0d exp 8", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    open_window();
    for (int k = 0; k < 5; k++) tick(1'b1, DS'(k), 1'b1);
    reset = 1'b1;
    tick(1'b0, '0, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick(1'b1, DS'(100 + k), 1'b1);
    repeat (12) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL rstmid cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
    n = 0;
    foreach (obs_q[k]) if (obs_q[k].en) begin
      tests++;
      if (obs_q[k].i !== DS'(102 + n)) begin
        fails++; $display("FAIL rstmid_val #%0d got i=%0d exp %0d", n, obs_q[k].i, 102 + n); end
      n++;
    end
    tests++; if (n != 8) begin fails++; $display("FAIL rstmid_count got %0d exp 8", n); end
    tests++; if (dut_ovf !== 1'b0) begin fails++; $display("FAIL rstmid_ovf got %b exp 0", dut_ovf); end
  endtask

  task automatic test_random();
    do_reset();
    open_window();
    for (int k = 0; k < 300; k++)
      tick(1'($urandom_range(0, 9) < 7), DS'($urandom), 1'($urandom_range(0, 9) < 6));
    repeat (40) tick(1'b0, '0, 1'b1);
    rec_on = 1'b0;
    foreach (obs_q[k]) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL random cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_cp0();
    logic [DS-1:0] qv[8];
    do_reset();
    out2_q.delete();
    rd2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      qv[k] = DS'($urandom);
      en2 = 1'b1; i2 = DS'(k); q2 = qv[k];
      @(negedge clk);
    end
    en2 = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (out2_q.size() != 8) begin
      fails++; $display("FAIL cp0_count got %0d exp 8", out2_q.size()); end
    foreach (out2_q[k]) begin
      tests++;
      if (k < 8 && out2_q[k] !== {1'(k == 0), DS'(k), qv[k]}) begin
        fails++; $display("FAIL cp0_val #%0d got %h exp %h", k, out2_q[k], {1'(k == 0), DS'(k), qv[k]});
      end
    end
`ifdef OFDM_RM_CP_OVF_EN
    tests++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL cp0_ovf got %b exp 0", ovf2); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    in_data_en = 1'b0; in_data_i = '0; in_data_q = '0; i_wayt_read_data = 1'b0;
    en2 = 1'b0; i2 = '0; q2 = '0; rd2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_to_back();
    test_overflow();
    test_toggle();
    test_reset_mid();
    test_random();
    test_cp0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
